// File: rtl/i2s_decoder_pkg.sv
// -----------------------------------------------------------------------------
// i2s_decoder_pkg
//   Shared definitions for the I2S receiver.
//   - state_e          : receiver framing state (HUNT / ALIGN / LOCK)
//   - DEF_DATA_WIDTH   : default bits per channel word
//   - DEF_SLOT_WIDTH   : default BCLK periods per LRCLK half-frame
// -----------------------------------------------------------------------------
package i2s_decoder_pkg;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_ALIGN = 2'd1,
        ST_LOCK  = 2'd2
    } state_e;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_SLOT_WIDTH = 32;

endpackage

// File: rtl/i2s_decoder_slot_timer.sv
// -----------------------------------------------------------------------------
// i2s_decoder_slot_timer
//   Tracks position inside the current LRCLK half-frame and flags the framing
//   events the receiver FSM reacts to. All flags are combinational and refer
//   to the sample taken on the current rising BCLK edge.
//
//   Ports
//     i_bclk        in   bit clock
//     i_rst_x       in   asynchronous active-low reset
//     i_lrclk       in   word select as sampled this edge
//     o_edge        out  LRCLK differs from the previous sample
//     o_legal_edge  out  edge arriving exactly one full slot after the last one
//     o_short_edge  out  edge arriving at any other position
//     o_overrun     out  no edge although a full slot has elapsed
//     o_shift_en    out  this sample carries a data bit
//     o_word_done   out  this sample carries the LSB of the word
// -----------------------------------------------------------------------------
module i2s_decoder_slot_timer
    import i2s_decoder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SLOT_WIDTH = DEF_SLOT_WIDTH
) (
    input  logic i_bclk,
    input  logic i_rst_x,
    input  logic i_lrclk,
    output logic o_edge,
    output logic o_legal_edge,
    output logic o_short_edge,
    output logic o_overrun,
    output logic o_shift_en,
    output logic o_word_done
);

    localparam int POS_W = $clog2(SLOT_WIDTH) + 1;

    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] POS_DATA = POS_W'(DATA_WIDTH);
    localparam logic [POS_W-1:0] POS_SLOT = POS_W'(SLOT_WIDTH);
    localparam logic [POS_W-1:0] POS_MAX  = '1;

    logic             lr_d_q, lr_d_d;
    logic [POS_W-1:0] pos_q,  pos_d;

    always_comb begin
        lr_d_d = i_lrclk;
        o_edge = (i_lrclk != lr_d_q);

        // Position 1 is the edge sample itself; the counter saturates so a
        // stalled LRCLK can never wrap around into a false legal edge.
        if (o_edge) begin
            pos_d = POS_ONE;
        end else if (pos_q != POS_MAX) begin
            pos_d = pos_q + POS_ONE;
        end else begin
            pos_d = pos_q;
        end

        o_legal_edge = o_edge && (pos_q == POS_SLOT);
        o_short_edge = o_edge && (pos_q != POS_SLOT);
        o_overrun    = !o_edge && (pos_q == POS_SLOT);
        o_shift_en   = !o_edge && (pos_q >= POS_ONE) && (pos_q <= POS_DATA);
        o_word_done  = !o_edge && (pos_q == POS_DATA);
    end

    always_ff @(posedge i_bclk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            lr_d_q <= 1'b0;
            pos_q  <= '0;
        end else begin
            lr_d_q <= lr_d_d;
            pos_q  <= pos_d;
        end
    end

endmodule

// File: rtl/i2s_decoder.sv
// -----------------------------------------------------------------------------
// i2s_decoder
//   I2S receiver. Deserialises MSB-first words from i_sdata, checks that the
//   LRCLK framing is regular and publishes every complete left+right pair.
//
//   Ports
//     i_bclk     in   bit clock, all state updates on its rising edge
//     i_rst_x    in   asynchronous active-low reset
//     i_lrclk    in   word select, 0 = left, 1 = right
//     i_sdata    in   serial data
//     o_data_l   out  last published left word
//     o_data_r   out  last published right word
//     o_valid    out  one-cycle pulse when o_data_l/o_data_r update
//     o_locked   out  framing verified
//     o_err      out  one-cycle pulse on a framing violation while locked
// -----------------------------------------------------------------------------
module i2s_decoder
    import i2s_decoder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SLOT_WIDTH = DEF_SLOT_WIDTH
) (
    input  logic                  i_bclk,
    input  logic                  i_rst_x,
    input  logic                  i_lrclk,
    input  logic                  i_sdata,
    output logic [DATA_WIDTH-1:0] o_data_l,
    output logic [DATA_WIDTH-1:0] o_data_r,
    output logic                  o_valid,
    output logic                  o_locked,
    output logic                  o_err
);

    logic edge_s, legal_edge, short_edge, overrun, shift_en, word_done;

    i2s_decoder_slot_timer #(
        .DATA_WIDTH (DATA_WIDTH),
        .SLOT_WIDTH (SLOT_WIDTH)
    ) u_slot_timer (
        .i_bclk       (i_bclk),
        .i_rst_x      (i_rst_x),
        .i_lrclk      (i_lrclk),
        .o_edge       (edge_s),
        .o_legal_edge (legal_edge),
        .o_short_edge (short_edge),
        .o_overrun    (overrun),
        .o_shift_en   (shift_en),
        .o_word_done  (word_done)
    );

    state_e                state_q,  state_d;
    logic [DATA_WIDTH-1:0] shift_q,  shift_d;
    logic [DATA_WIDTH-1:0] left_q,   left_d;
    logic                  held_q,   held_d;
    logic [DATA_WIDTH-1:0] data_l_q, data_l_d;
    logic [DATA_WIDTH-1:0] data_r_q, data_r_d;
    logic                  valid_q,  valid_d;
    logic                  locked_q, locked_d;
    logic                  err_q,    err_d;

    logic [DATA_WIDTH-1:0] word;
    logic                  timing_err;

    always_comb begin
        word       = {shift_q[DATA_WIDTH-2:0], i_sdata};
        timing_err = short_edge || overrun;

        state_d  = state_q;
        shift_d  = shift_en ? word : shift_q;
        left_d   = left_q;
        held_d   = held_q;
        data_l_d = data_l_q;
        data_r_d = data_r_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (edge_s) begin
                    state_d = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                // Bad edges or overruns here only re-arm the slot counter,
                // which the timer does on its own at the next edge.
                if (legal_edge) begin
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (timing_err) begin
                    state_d = ST_ALIGN;
                    err_d   = 1'b1;
                    held_d  = 1'b0;
                end else if (word_done) begin
                    // A completion is never an edge sample, so i_lrclk
                    // still names the slot the word belongs to.
                    if (!i_lrclk) begin
                        left_d = word;
                        held_d = 1'b1;
                    end else if (held_q) begin
                        data_l_d = left_q;
                        data_r_d = word;
                        valid_d  = 1'b1;
                        held_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        locked_d = (state_d == ST_LOCK);
    end

    always_ff @(posedge i_bclk or negedge i_rst_x) begin
        if (!i_rst_x) begin
            state_q  <= ST_HUNT;
            shift_q  <= '0;
            left_q   <= '0;
            held_q   <= 1'b0;
            data_l_q <= '0;
            data_r_q <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            left_q   <= left_d;
            held_q   <= held_d;
            data_l_q <= data_l_d;
            data_r_q <= data_r_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign o_data_l = data_l_q;
    assign o_data_r = data_r_q;
    assign o_valid  = valid_q;
    assign o_locked = locked_q;
    assign o_err    = err_q;

endmodule

// File: tb/tb_i2s_decoder.sv
// -----------------------------------------------------------------------------
// tb_i2s_decoder
//   Directed bench for i2s_decoder. A transmitter model drives LRCLK/SDATA on
//   the falling BCLK edge; a monitor records every published pair and every
//   error pulse on the falling edge.
// -----------------------------------------------------------------------------
module tb_i2s_decoder;

    logic        bclk  = 1'b0;
    logic        rst_x = 1'b0;
    logic        lrclk = 1'b0;
    logic        sdata = 1'b0;
    logic [15:0] data_l;
    logic [15:0] data_r;
    logic        valid;
    logic        locked;
    logic        err;

    int errors = 0;
    int checks = 0;

    int          cyc = 0;
    logic [31:0] pub_q[$];
    int          pub_cyc[$];
    int          err_pulses = 0;

    i2s_decoder #(
        .DATA_WIDTH (16),
        .SLOT_WIDTH (32)
    ) dut (
        .i_bclk   (bclk),
        .i_rst_x  (rst_x),
        .i_lrclk  (lrclk),
        .i_sdata  (sdata),
        .o_data_l (data_l),
        .o_data_r (data_r),
        .o_valid  (valid),
        .o_locked (locked),
        .o_err    (err)
    );

    always #5 bclk = ~bclk;

    always @(posedge bclk) cyc++;

    always @(negedge bclk) begin
        if (valid) begin
            pub_q.push_back({data_l, data_r});
            pub_cyc.push_back(cyc);
        end
        if (err) err_pulses++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pub_at(input int idx);
        if (idx >= 0 && idx < pub_q.size()) return pub_q[idx];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pub_gap(input int idx);
        if (idx >= 1 && idx < pub_cyc.size()) return 32'(pub_cyc[idx] - pub_cyc[idx-1]);
        return 32'hFFFF_FFFF;
    endfunction

    // One LRCLK half-frame: bit 0 is the edge/padding bit, bits 1..16 carry
    // the word MSB first, the rest is padding.
    task automatic send_slot(input logic lr, input logic [15:0] w, input int len, input logic pad);
        for (int i = 0; i < len; i++) begin
            @(negedge bclk);
            lrclk = lr;
            if (i >= 1 && i <= 16) sdata = w[16-i];
            else                   sdata = pad;
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input logic pad);
        send_slot(1'b0, l, 32, pad);
        send_slot(1'b1, r, 32, pad);
        #2;
    endtask

    logic [15:0] tab_l [4] = '{16'h1357, 16'h2468, 16'h9ABC, 16'hFEDC};
    logic [15:0] tab_r [4] = '{16'h0001, 16'hFFFE, 16'h4321, 16'hC0DE};

    initial begin
        int n;
        int e;

        // Reset state
        repeat (3) @(negedge bclk);
        #2;
        check("rst_data_l", 32'(data_l), 32'h0);
        check("rst_data_r", 32'(data_r), 32'h0);
        check("rst_valid",  32'(valid),  32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_err",    32'(err),    32'h0);
        @(negedge bclk);
        rst_x = 1'b1;

        // 1: loopback A55A / 0FF0
        send_frame(16'hA55A, 16'h0FF0, 1'b0);
        check("t1_unlocked_after_1_edge", 32'(locked), 32'h0);
        check("t1_no_pub_before_lock", 32'(pub_q.size()), 32'd0);
        send_frame(16'hA55A, 16'h0FF0, 1'b0);
        check("t1_locked_after_2_edges", 32'(locked), 32'h1);
        check("t1_first_pair_count", 32'(pub_q.size()), 32'd1);
        check("t1_first_pair", pub_at(0), 32'hA55A_0FF0);
        send_frame(16'hA55A, 16'h0FF0, 1'b0);
        send_frame(16'hA55A, 16'h0FF0, 1'b0);
        check("t1_pair_count", 32'(pub_q.size()), 32'd3);
        check("t1_third_pair", pub_at(2), 32'hA55A_0FF0);
        check("t1_period", pub_gap(2), 32'd64);
        check("t1_no_err", 32'(err_pulses), 32'd0);

        // 2: extreme values with padding driven high
        send_frame(16'h8000, 16'h7FFF, 1'b1);
        check("t2_pair_count", 32'(pub_q.size()), 32'd4);
        check("t2_pair", pub_at(3), 32'h8000_7FFF);
        check("t2_outputs_held", {data_l, data_r}, 32'h8000_7FFF);

        // 3: one 33-BCLK left slot
        n = pub_q.size();
        e = err_pulses;
        send_slot(1'b0, 16'h1234, 33, 1'b0);
        send_slot(1'b1, 16'h5678, 32, 1'b0);
        #2;
        check("t3_err_single", 32'(err_pulses), 32'(e + 1));
        check("t3_unlocked", 32'(locked), 32'h0);
        check("t3_pair_dropped", 32'(pub_q.size()), 32'(n));
        send_frame(16'h1111, 16'h2222, 1'b0);
        check("t3_relocked", 32'(locked), 32'h1);
        check("t3_pair_count", 32'(pub_q.size()), 32'(n + 1));
        check("t3_pair", pub_at(n), 32'h1111_2222);

        // 4: LRCLK held low for 40 BCLKs
        n = pub_q.size();
        e = err_pulses;
        send_slot(1'b0, 16'h3333, 40, 1'b0);
        send_slot(1'b1, 16'h4444, 32, 1'b0);
        #2;
        check("t4_err_single", 32'(err_pulses), 32'(e + 1));
        check("t4_unlocked", 32'(locked), 32'h0);
        check("t4_no_pub", 32'(pub_q.size()), 32'(n));
        send_frame(16'h5555, 16'h6666, 1'b0);
        check("t4_relocked", 32'(locked), 32'h1);
        check("t4_pair", pub_at(n), 32'h5555_6666);

        // 5: asynchronous reset in the middle of a right word
        n = pub_q.size();
        send_slot(1'b0, 16'h7777, 32, 1'b0);
        send_slot(1'b1, 16'h8888, 8, 1'b0);
        #2;
        rst_x = 1'b0;
        #1;
        check("t5_rst_data_l", 32'(data_l), 32'h0);
        check("t5_rst_data_r", 32'(data_r), 32'h0);
        check("t5_rst_valid",  32'(valid),  32'h0);
        check("t5_rst_locked", 32'(locked), 32'h0);
        check("t5_rst_err",    32'(err),    32'h0);
        @(negedge bclk);
        lrclk = 1'b0;
        sdata = 1'b0;
        repeat (3) @(negedge bclk);
        rst_x = 1'b1;
        check("t5_no_partial_pub", 32'(pub_q.size()), 32'(n));
        send_frame(16'h9999, 16'hAAAA, 1'b0);
        check("t5_unlocked_1_edge", 32'(locked), 32'h0);
        check("t5_no_pub_unlocked", 32'(pub_q.size()), 32'(n));
        send_frame(16'hBBBB, 16'hCCCC, 1'b0);
        check("t5_relocked", 32'(locked), 32'h1);
        check("t5_pair", pub_at(n), 32'hBBBB_CCCC);

        // 6: four frames of changing data
        n = pub_q.size();
        for (int k = 0; k < 4; k++) send_frame(tab_l[k], tab_r[k], 1'b0);
        check("t6_pair_count", 32'(pub_q.size()), 32'(n + 4));
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t6_pair%0d", k), pub_at(n + k), {tab_l[k], tab_r[k]});
        end
        check("t6_period", pub_gap(n + 3), 32'd64);
        check("t6_still_locked", 32'(locked), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
